// File: rtl/ff_delay_line_if.sv
// ff_delay_line_if: data/control/config bundle for the delay line.
// master drives data_in/valid_in/data_init/control/config and reads data_out/valid_out/occupancy.
interface ff_delay_line_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] io_data_in;
  logic             io_valid_in;
  logic [WIDTH-1:0] io_data_init;
  logic             io_control_enable;
  logic             io_control_flush;
  logic [DW-1:0]    io_config_delay;
  logic [WIDTH-1:0] io_data_out;
  logic             io_valid_out;
  logic [DW-1:0]    io_occupancy;

  modport master (
    output io_data_in,
    output io_valid_in,
    output io_data_init,
    output io_control_enable,
    output io_control_flush,
    output io_config_delay,
    input  io_data_out,
    input  io_valid_out,
    input  io_occupancy
  );

  modport slave (
    input  io_data_in,
    input  io_valid_in,
    input  io_data_init,
    input  io_control_enable,
    input  io_control_flush,
    input  io_config_delay,
    output io_data_out,
    output io_valid_out,
    output io_occupancy
  );
endinterface

// File: rtl/ff_delay_line.sv
// ff_delay_line: stallable, flushable delay line with runtime tap 0..DEPTH.
// Ports: clk, reset (async, active-high), bus (ff_delay_line_if.slave).
module ff_delay_line #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  ff_delay_line_if.slave   bus
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DW-1:0]    dly;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic [DW-1:0]    occ_o;

  // Next state: flush beats enable beats hold.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (bus.io_control_flush) begin
      vld_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = bus.io_data_init;
      end
    end else if (bus.io_control_enable) begin
      data_d[0] = bus.io_data_in;
      vld_d[0]  = bus.io_valid_in;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= INIT;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Out-of-range delays saturate to the last physical stage.
  always_comb begin
    if (bus.io_config_delay > DW'(DEPTH)) begin
      dly = DW'(DEPTH);
    end else begin
      dly = bus.io_config_delay;
    end
  end

  // d=0 bypasses the registers entirely.
  always_comb begin
    data_o  = bus.io_data_in;
    valid_o = bus.io_valid_in;
    occ_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dly == DW'(i + 1)) begin
        data_o  = data_q[i];
        valid_o = vld_q[i];
      end
      if (DW'(i) < dly) begin
        occ_o = occ_o + DW'(vld_q[i]);
      end
    end
  end

  assign bus.io_data_out  = data_o;
  assign bus.io_valid_out = valid_o;
  assign bus.io_occupancy = occ_o;
endmodule

// File: doc/ff_delay_line.md
# ff_delay_line

Parametrised, stallable delay line with a runtime-selectable tap, used as the pipeline-balancing register stage between compute-unit pipeline stages and counter outputs. It generalises the single enabled init-flop: configurable width and depth, per-stage valid tracking, a synchronous flush to a runtime init value, and a programmable delay of 0..DEPTH cycles.

## Interface
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 8, number of physical register stages (≥1)
- INIT, 0, WIDTH-bit value loaded into every data stage by reset
- DW, $clog2(DEPTH+1), width of delay/occupancy fields (derived, not overridden)

- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears state immediately, released synchronously by the system
- io_data_in  in  WIDTH  data entering stage 0
- io_valid_in  in  1  qualifies io_data_in
- io_data_init  in  WIDTH  value loaded into all stages on flush
- io_control_enable  in  1  1 = advance pipeline; 0 = hold all stages
- io_control_flush  in  1  synchronous flush
- io_config_delay  in  DW  selected delay in cycles; values >DEPTH saturate to DEPTH
- io_data_out  out  WIDTH  data at selected tap
- io_valid_out  out  1  valid at selected tap
- io_occupancy  out  DW  number of valid entries in stages 0..d-1

## Operation
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1].
- Reset (async): data[i]=INIT, vld[i]=0 for all i.
- Per edge, priority flush > enable > hold:
  - flush=1: data[i]=io_data_init, vld[i]=0 for all i; io_data_in/io_valid_in discarded regardless of enable.
  - else enable=1: data[0]=io_data_in, vld[0]=io_valid_in; data[i]=data[i-1], vld[i]=vld[i-1] for i≥1; data[DEPTH-1] falls off.
  - else: all stages hold.
- Data shifts regardless of valid; valid is a sideband, not a gate.
- Effective delay d = min(io_config_delay, DEPTH).
- Output mux (combinational from state and config):
  - d=0: io_data_out=io_data_in, io_valid_out=io_valid_in (bypass).
  - d≥1: io_data_out=data[d-1], io_valid_out=vld[d-1].
- io_occupancy = popcount(vld[0..d-1]); 0 when d=0.
- Config change mid-stream: takes effect combinationally the same cycle; no stage contents are moved or dropped; entries beyond the new tap continue shifting and are simply not observed.

## Timing
- Latency: sample accepted on an edge with enable=1, flush=0 appears at io_data_out after exactly d enabled edges; each enable=0 cycle adds one cycle.
- Throughput: one sample per enabled cycle, no bubbles inserted.
- Reset values: io_data_out=INIT (d≥1) or io_data_in (d=0); io_valid_out=0 (d≥1) or io_valid_in (d=0); io_occupancy=0.
- Reset asserted mid-operation: outputs reach reset values asynchronously, before the next edge; in-flight data lost.
- Flush edge: from next cycle io_data_out=io_data_init value sampled at that edge (d≥1), io_valid_out=0, io_occupancy=0.
- Flush with enable=0 still flushes.
- d=0 path is purely combinational; no registered output.

## Test plan
Configuration WIDTH=8, DEPTH=4, INIT=0xA5.
- Reset: assert reset with clk stopped, config_delay=2 -> io_data_out=0xA5, io_valid_out=0, io_occupancy=0 without any clock edge.
- Latency: delay=3, enable=1, drive 0x01,0x02,0x03 valid on consecutive edges -> 0x01 with valid_out=1 visible after the 3rd edge, then 0x02, 0x03; occupancy peaks at 3.
- Stall: delay=2, push 0x10 valid, hold enable=0 for 3 cycles -> io_data_out unchanged during stall; 0x10 appears after the 2nd enabled edge (5 cycles total).
- Flush priority: pipeline full of valid data, io_data_init=0x3C, flush=1 and enable=1 with valid_in=1, data_in=0x77 -> next cycle all taps show 0x3C, valid_out=0, occupancy=0; 0x77 never appears.
- Tap switch and saturation: stream 0x20..0x27 valid, delay=1 then switch to 7 -> output immediately shows data[3] (saturated d=4), no dropped or reordered samples at the new tap; delay=0 -> io_data_out tracks io_data_in same cycle.
